// File: rtl/load_ext_unit.sv
// load_ext_unit: MEM-stage load unit. Accepts LB/LBU/LH/LHU/LW, issues a word-aligned
// byte-lane read on a req/ack data bus, extends the addressed byte/halfword, stalls the
// pipeline while the read is outstanding, and reports misaligned-address and timeout faults.
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   ld_valid, op, addr    MEM-stage instruction valid, opcode instr[31:26], effective address
//   flush                 kill the MEM-stage instruction
//   mem_req/addr/be       read request, word address, byte lanes (held until ack/timeout)
//   mem_ack, mem_rdata    read data valid strobe and read word (byte 0 = [7:0])
//   ld_data, ld_done      extended load result and its one-cycle write-back pulse
//   stall                 freeze pipeline stages up to and including MEM
//   adel, bus_err         one-cycle fault pulses: misaligned address, ack timeout
module load_ext_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic        ld_done,
  output logic        stall,
  output logic        adel,
  output logic        bus_err
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [1:0]       a_q, a_d;
  logic             mem_req_d, adel_d, bus_err_d;
  logic [31:0]      mem_addr_d, ld_data_d;
  logic [3:0]       mem_be_d;

  logic             is_load_c, misaligned_c, accept_c, timeout_c;
  logic [3:0]       be_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      ext_c;

  // Opcode decode, alignment and lane selection for the incoming instruction
  always_comb begin
    is_load_c    = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
                   (op == OP_LHU) || (op == OP_LW);
    misaligned_c = (((op == OP_LH) || (op == OP_LHU)) && addr[0]) ||
                   ((op == OP_LW) && (addr[1:0] != 2'b00));
    accept_c     = (state_q == S_IDLE) && ld_valid && is_load_c && !flush;
    timeout_c    = (cnt_q == CNT_LAST);
    if (op == OP_LW)                          be_c = 4'b1111;
    else if ((op == OP_LH) || (op == OP_LHU)) be_c = addr[1] ? 4'b1100 : 4'b0011;
    else                                      be_c = 4'b0001 << addr[1:0];
  end

  // Byte/halfword extraction from the read word using the latched offset and opcode
  always_comb begin
    case (a_q)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ext_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  ext_c = {24'h0, byte_c};
      OP_LH:   ext_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  ext_c = {16'h0, half_c};
      default: ext_c = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ack wins over timeout, and a flushed read still waits out its ack in DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = misaligned_c ? S_DONE : S_REQ;
      S_REQ: begin
        if (mem_ack || timeout_c) state_d = flush ? S_IDLE : S_DONE;
        else if (flush)           state_d = S_DRAIN;
      end
      S_DRAIN: if (mem_ack || timeout_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for registered outputs, plus stall and ld_done directly
  always_comb begin
    mem_req_d  = 1'b0;
    adel_d     = 1'b0;
    bus_err_d  = 1'b0;
    cnt_d      = '0;
    op_d       = op_q;
    a_d        = a_q;
    mem_addr_d = mem_addr;
    mem_be_d   = mem_be;
    ld_data_d  = ld_data;
    stall      = 1'b0;
    ld_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (misaligned_c) begin
            adel_d    = 1'b1;
            ld_data_d = '0;
          end else begin
            stall      = 1'b1;
            mem_req_d  = 1'b1;
            op_d       = op;
            a_d        = addr[1:0];
            mem_addr_d = {addr[31:2], 2'b00};
            mem_be_d   = be_c;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem_ack) begin
          if (!flush) ld_data_d = ext_c;
        end else if (timeout_c) begin
          if (!flush) begin
            bus_err_d = 1'b1;
            ld_data_d = '0;
          end
        end else begin
          mem_req_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        stall = 1'b1;
        if (!mem_ack && !timeout_c) begin
          mem_req_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: ld_done = !flush && !adel && !bus_err;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_be   <= '0;
      ld_data  <= '0;
      adel     <= 1'b0;
      bus_err  <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
    end else begin
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      mem_be   <= mem_be_d;
      ld_data  <= ld_data_d;
      adel     <= adel_d;
      bus_err  <= bus_err_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
    end
  end

endmodule

// File: tb/tb_load_ext_unit.sv
// tb_load_ext_unit: scoreboard bench for load_ext_unit. Each load pushes its expected
// completion (write-back, misaligned fault or timeout fault) and a monitor pops and compares
// whenever the DUT signals completion. Bus handshake and stall are checked inline.
module tb_load_ext_unit;

  localparam int unsigned TO = 8;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_ADEL = 2'd1;
  localparam logic [1:0] K_BUS  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst_n, ld_valid, flush, mem_req, mem_ack;
  logic        ld_done, stall, adel, bus_err;
  logic [5:0]  op;
  logic [31:0] addr, mem_addr, mem_rdata, ld_data;
  logic [3:0]  mem_be;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  load_ext_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .op(op), .addr(addr), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ld_data(ld_data), .ld_done(ld_done), .stall(stall),
    .adel(adel), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Completion monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && (ld_done || adel || bus_err)) begin
      exp_t e;
      logic [1:0] k;
      k = ld_done ? K_DONE : (adel ? K_ADEL : K_BUS);
      check("onehot_done", 32'(ld_done) + 32'(adel) + 32'(bus_err), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 32'(k), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_kind", 32'(k), 32'(e.kind));
        check("sb_ld_data", ld_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one load; ack arrives in REQ cycle 'lat' (unreachable lat = no ack)
  task automatic do_load(input logic [5:0] o, input logic [31:0] a, input logic [31:0] rd,
                         input int lat, input logic [3:0] exp_be,
                         input logic [1:0] kind, input logic [31:0] exp_data);
    int cyc;
    ld_valid = 1'b1;
    op       = o;
    addr     = a;
    exp_q.push_back('{kind, exp_data});
    @(negedge clk);
    check("stall_accept", 32'(stall), 32'(kind != K_ADEL));
    tick();
    if (kind == K_ADEL) begin
      ld_valid = 1'b0;
      @(negedge clk);
      check("adel_no_req", 32'(mem_req), 32'd0);
      check("adel_no_stall", 32'(stall), 32'd0);
      tick();
    end else begin
      cyc = 0;
      while (1) begin
        if (cyc == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        @(negedge clk);
        if (cyc == 0) begin
          check("mem_addr", mem_addr, {a[31:2], 2'b00});
          check("mem_be", 32'(mem_be), 32'(exp_be));
        end
        check("req_held", 32'(mem_req), 32'd1);
        check("stall_req", 32'(stall), 32'd1);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom();
        if (cyc == lat || cyc == int'(TO) - 1) break;
        cyc++;
      end
      ld_valid = 1'b0;
      @(negedge clk);
      check("stall_done", 32'(stall), 32'd0);
      check("req_dropped", 32'(mem_req), 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    op        = '0;
    addr      = '0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_flags", {29'd0, ld_done, adel, bus_err}, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Byte and halfword extraction
    do_load(OP_LB,  32'h101, 32'h1234_80FF, 0, 4'b0010, K_DONE, 32'hFFFF_FF80);
    do_load(OP_LBU, 32'h101, 32'h1234_80FF, 0, 4'b0010, K_DONE, 32'h0000_0080);
    do_load(OP_LH,  32'h102, 32'hBEEF_0000, 0, 4'b1100, K_DONE, 32'hFFFF_BEEF);
    do_load(OP_LHU, 32'h102, 32'hBEEF_0000, 1, 4'b1100, K_DONE, 32'h0000_BEEF);
    do_load(OP_LB,  32'h103, 32'h7F00_0000, 0, 4'b1000, K_DONE, 32'h0000_007F);
    do_load(OP_LBU, 32'h100, 32'hAABB_CCDD, 2, 4'b0001, K_DONE, 32'h0000_00DD);
    do_load(OP_LB,  32'h102, 32'hAA99_CCDD, 0, 4'b0100, K_DONE, 32'hFFFF_FF99);
    do_load(OP_LH,  32'h100, 32'h0000_8001, 0, 4'b0011, K_DONE, 32'hFFFF_8001);
    do_load(OP_LW,  32'h200, 32'hCAFE_F00D, 3, 4'b1111, K_DONE, 32'hCAFE_F00D);

    // Misaligned addresses
    do_load(OP_LH,  32'h101, 32'h0,         0, 4'b0000, K_ADEL, 32'h0);
    do_load(OP_LW,  32'h202, 32'h0,         0, 4'b0000, K_ADEL, 32'h0);
    do_load(OP_LHU, 32'h103, 32'h0,         0, 4'b0000, K_ADEL, 32'h0);

    // Timeout: no ack for TO cycles
    do_load(OP_LW,  32'h304, 32'h0,       100, 4'b1111, K_BUS,  32'h0);

    // Non-load op and flushed instruction: no accept
    ld_valid = 1'b1;
    op       = OP_SW;
    addr     = 32'h500;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("nonload_stall", 32'(stall), 32'd0);
      tick();
      check("nonload_req", 32'(mem_req), 32'd0);
    end
    op    = OP_LW;
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", 32'(stall), 32'd0);
    tick();
    check("flush_idle_req", 32'(mem_req), 32'd0);
    flush = 1'b0;

    // Flush in the 2nd REQ cycle, ack two cycles later: drain without write-back
    addr = 32'h600;
    tick();
    @(negedge clk);
    check("fl_req0", 32'(mem_req), 32'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("fl_req1", 32'(mem_req), 32'd1);
    tick();
    flush    = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    check("drain_req", 32'(mem_req), 32'd1);
    check("drain_stall", 32'(stall), 32'd1);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("drain_req_ack", 32'(mem_req), 32'd1);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    check("drain_released", 32'(mem_req), 32'd0);
    check("drain_idle_stall", 32'(stall), 32'd0);
    tick();
    do_load(OP_LHU, 32'h702, 32'h8765_4321, 1, 4'b1100, K_DONE, 32'h0000_8765);

    // Reset mid-transaction: request abandoned, late ack ignored
    ld_valid = 1'b1;
    op       = OP_LW;
    addr     = 32'h800;
    tick();
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req), 32'd1);
    tick();
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_req_drop", 32'(mem_req), 32'd0);
    check("rst_mid_ld_data", ld_data, 32'd0);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    check("late_ack_stall", 32'(stall), 32'd0);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", 32'(mem_req), 32'd0);
    tick();
    do_load(OP_LW,  32'h900, 32'h0123_4567, 0, 4'b1111, K_DONE, 32'h0123_4567);

    tick();
    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
